// File: rtl/ff_network_mac.sv
// Two-layer feed-forward network (input -> hidden -> output) sharing one signed MAC behind a host register map.
// Define FF_NETWORK_BIAS_EN to add per-neuron bias registers preloaded into the accumulator.
module ff_network_mac #(
  parameter int WIDTH      = 32,
  parameter int LENGHT_I   = 8,
  parameter int LENGHT_MID = 4,
  parameter int LENGHT_O   = 2,
  parameter int WIDTH_I    = 8,
  parameter int WIDTH_W    = 9,
  parameter int RANGE_SIGM = 1000,
  parameter int SHIFT      = 2,
  parameter int WIDTH_ACT  = $clog2(RANGE_SIGM),
  parameter int WIDTH_ACC  = WIDTH_ACT + 1 + WIDTH_W +
                             $clog2((LENGHT_I > LENGHT_MID) ? LENGHT_I : LENGHT_MID) + 1,
  parameter int WIDTH_ADDR = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + 1 +
                                    2*LENGHT_O + LENGHT_MID)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [WIDTH_ADDR-1:0] address,
  input  logic [WIDTH-1:0]      in_d,
  output logic [WIDTH-1:0]      out_d,
  output logic                  ready,
  output logic                  down
);

  localparam int NW1    = LENGHT_I * LENGHT_MID;
  localparam int NW     = NW1 + LENGHT_MID * LENGHT_O;
  localparam int BASE_I = NW;
  localparam int BASE_C = BASE_I + LENGHT_I;
  localparam int BASE_O = BASE_C + 1;
  localparam int BASE_B = BASE_O + LENGHT_O;
  localparam int NB     = LENGHT_MID + LENGHT_O;

  localparam logic [WIDTH_ADDR-1:0] LAST_I   = WIDTH_ADDR'(LENGHT_I - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_MID = WIDTH_ADDR'(LENGHT_MID - 1);
  localparam logic [WIDTH_ADDR-1:0] LAST_O   = WIDTH_ADDR'(LENGHT_O - 1);

  typedef enum logic [2:0] {IDLE, MAC1, ACT1, MAC2, ACT2, DONE} state_t;

  state_t                        state_q, state_d;
  logic [WIDTH_ADDR-1:0]         cnt_q, cnt_d;
  logic [WIDTH_ADDR-1:0]         neu_q, neu_d;
  logic signed [WIDTH_ACC-1:0]   acc_q, acc_d;
  logic                          down_q, down_d;
  logic [WIDTH-1:0]              rdata_q, rdata_d;

  logic signed [WIDTH_W-1:0]     weight_q [NW];
  logic signed [WIDTH_W-1:0]     weight_d [NW];
  logic signed [WIDTH_I-1:0]     x_q [LENGHT_I];
  logic signed [WIDTH_I-1:0]     x_d [LENGHT_I];
  logic [WIDTH_ACT-1:0]          mid_q [LENGHT_MID];
  logic [WIDTH_ACT-1:0]          mid_d [LENGHT_MID];
  logic [WIDTH_ACT-1:0]          res_q [LENGHT_O];
  logic [WIDTH_ACT-1:0]          res_d [LENGHT_O];
`ifdef FF_NETWORK_BIAS_EN
  logic signed [WIDTH_W-1:0]     bias_q [NB];
  logic signed [WIDTH_W-1:0]     bias_d [NB];
  int                            bias_idx;
`endif

  logic                          idle, host_wr, start;
  int                            w_idx;
  logic signed [WIDTH_ACC-1:0]   op_w, op_x, product, preload;
  logic signed [WIDTH_ACC-1:0]   shifted, act_sum;
  logic [WIDTH_ACT-1:0]          act_val;
  logic                          unused_in_bits;

  assign idle           = (state_q == IDLE);
  assign host_wr        = write && idle;
  assign start          = host_wr && (address == WIDTH_ADDR'(BASE_C)) && in_d[0];
  assign unused_in_bits = ^in_d[WIDTH-1:WIDTH_W];

  // Operand and bias selection for the shared MAC; layer 2 treats mid as unsigned.
  always_comb begin
    op_w    = '0;
    op_x    = '0;
    preload = '0;
    if (state_q == MAC2) w_idx = NW1 + int'(neu_q) * LENGHT_MID + int'(cnt_q);
    else                 w_idx = int'(neu_q) * LENGHT_I + int'(cnt_q);
    for (int n = 0; n < NW; n++)
      if (n == w_idx) op_w = WIDTH_ACC'(weight_q[n]);
    if (state_q == MAC2) begin
      for (int n = 0; n < LENGHT_MID; n++)
        if (n == int'(cnt_q)) op_x = WIDTH_ACC'(mid_q[n]);
    end else begin
      for (int n = 0; n < LENGHT_I; n++)
        if (n == int'(cnt_q)) op_x = WIDTH_ACC'(x_q[n]);
    end
`ifdef FF_NETWORK_BIAS_EN
    case (state_q)
      ACT1:    bias_idx = (neu_q == LAST_MID) ? LENGHT_MID : int'(neu_q) + 1;
      ACT2:    bias_idx = LENGHT_MID + int'(neu_q) + 1;
      default: bias_idx = 0;
    endcase
    for (int n = 0; n < NB; n++)
      if (n == bias_idx) preload = WIDTH_ACC'(bias_q[n]);
`endif
  end

  always_comb begin
    product = op_w * op_x;
    shifted = acc_q >>> SHIFT;
    act_sum = shifted + WIDTH_ACC'(RANGE_SIGM / 2);
    if (act_sum < 0)                               act_val = '0;
    else if (act_sum > WIDTH_ACC'(RANGE_SIGM - 1)) act_val = WIDTH_ACT'(RANGE_SIGM - 1);
    else                                           act_val = act_sum[WIDTH_ACT-1:0];
  end

  // Sequencer: each neuron is LENGHT_* MAC cycles plus one activation cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neu_d   = neu_q;
    acc_d   = acc_q;
    down_d  = down_q;
    mid_d   = mid_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = MAC1;
        cnt_d   = '0;
        neu_d   = '0;
        acc_d   = preload;
        down_d  = 1'b0;
      end
      MAC1: begin
        acc_d = acc_q + product;
        if (cnt_q == LAST_I) begin
          cnt_d   = '0;
          state_d = ACT1;
        end else cnt_d = cnt_q + 1'b1;
      end
      ACT1: begin
        for (int n = 0; n < LENGHT_MID; n++)
          if (n == int'(neu_q)) mid_d[n] = act_val;
        acc_d = preload;
        if (neu_q == LAST_MID) begin
          neu_d   = '0;
          state_d = MAC2;
        end else begin
          neu_d   = neu_q + 1'b1;
          state_d = MAC1;
        end
      end
      MAC2: begin
        acc_d = acc_q + product;
        if (cnt_q == LAST_MID) begin
          cnt_d   = '0;
          state_d = ACT2;
        end else cnt_d = cnt_q + 1'b1;
      end
      ACT2: begin
        for (int n = 0; n < LENGHT_O; n++)
          if (n == int'(neu_q)) res_d[n] = act_val;
        acc_d = preload;
        if (neu_q == LAST_O) state_d = DONE;
        else begin
          neu_d   = neu_q + 1'b1;
          state_d = MAC2;
        end
      end
      DONE: begin
        down_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    weight_d = weight_q;
    x_d      = x_q;
`ifdef FF_NETWORK_BIAS_EN
    bias_d   = bias_q;
`endif
    if (host_wr) begin
      for (int n = 0; n < NW; n++)
        if (address == WIDTH_ADDR'(n)) weight_d[n] = in_d[WIDTH_W-1:0];
      for (int n = 0; n < LENGHT_I; n++)
        if (address == WIDTH_ADDR'(BASE_I + n)) x_d[n] = in_d[WIDTH_I-1:0];
`ifdef FF_NETWORK_BIAS_EN
      for (int n = 0; n < NB; n++)
        if (address == WIDTH_ADDR'(BASE_B + n)) bias_d[n] = in_d[WIDTH_W-1:0];
`endif
    end
  end

  // Read data always reflects pre-write register contents.
  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      rdata_d = '0;
      for (int n = 0; n < NW; n++)
        if (address == WIDTH_ADDR'(n)) rdata_d = WIDTH'(weight_q[n]);
      for (int n = 0; n < LENGHT_I; n++)
        if (address == WIDTH_ADDR'(BASE_I + n)) rdata_d = WIDTH'(x_q[n]);
      if (address == WIDTH_ADDR'(BASE_C)) rdata_d = {{(WIDTH-2){1'b0}}, down_q, ~idle};
      for (int n = 0; n < LENGHT_O; n++)
        if (address == WIDTH_ADDR'(BASE_O + n)) rdata_d = WIDTH'(res_q[n]);
`ifdef FF_NETWORK_BIAS_EN
      for (int n = 0; n < NB; n++)
        if (address == WIDTH_ADDR'(BASE_B + n)) rdata_d = WIDTH'(bias_q[n]);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      neu_q    <= '0;
      acc_q    <= '0;
      down_q   <= 1'b0;
      rdata_q  <= '0;
      weight_q <= '{default: '0};
      x_q      <= '{default: '0};
      mid_q    <= '{default: '0};
      res_q    <= '{default: '0};
`ifdef FF_NETWORK_BIAS_EN
      bias_q   <= '{default: '0};
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neu_q    <= neu_d;
      acc_q    <= acc_d;
      down_q   <= down_d;
      rdata_q  <= rdata_d;
      weight_q <= weight_d;
      x_q      <= x_d;
      mid_q    <= mid_d;
      res_q    <= res_d;
`ifdef FF_NETWORK_BIAS_EN
      bias_q   <= bias_d;
`endif
    end
  end

  assign out_d = rdata_q;
  assign ready = idle;
  assign down  = down_q;

endmodule

// File: tb/tb_ff_network_mac.sv
// Scoreboard bench for ff_network_mac: stimulus pushes expectations, a monitor pops and compares.
module tb_ff_network_mac;

  localparam int AW       = 6;
  localparam int K_READ   = 0;
  localparam int K_STATUS = 1;
  localparam int K_VALUE  = 2;
  localparam int LAT      = 47;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] address = '0;
  logic [31:0]   in_d = '0;
  logic [31:0]   out_d;
  logic          ready, down;

  typedef struct {
    int          kind;
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cyc = 0;
  logic        stat_req = 1'b0;
  logic        val_req = 1'b0;
  logic [31:0] chk_val = '0;
  int          s;

  ff_network_mac dut (
    .clk(clk), .reset(reset), .read(read), .write(write),
    .address(address), .in_d(in_d), .out_d(out_d), .ready(ready), .down(down)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used to time runs from the start write edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input int kind, input logic [31:0] act);
    exp_t e;
    n_compared++;
    if (sb_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL unexpected_output kind=%0d got=%0d need=none", kind, act);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != kind || act !== e.exp) begin
        n_mismatched++;
        $display("[TB] FAIL %s got=%0d (0x%08h) need=%0d (0x%08h)", e.name, act, act, e.exp, e.exp);
      end
    end
  endtask

  // Monitor: samples just after each rising edge, popping one expectation per presented result.
  initial forever begin
    @(posedge clk);
    #1;
    if (read && !reset) compare(K_READ, out_d);
    if (stat_req)       compare(K_STATUS, {30'b0, ready, down});
    if (val_req)        compare(K_VALUE, chk_val);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired got=timeout need=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void pushExp(input int kind, input string nm, input logic [31:0] e);
    exp_t x;
    x.kind = kind;
    x.name = nm;
    x.exp  = e;
    sb_q.push_back(x);
  endfunction

  task automatic applyStimulus(input logic wr, input logic rd, input int addr, input logic [31:0] data);
    @(negedge clk);
    write   = wr;
    read    = rd;
    address = AW'(addr);
    in_d    = data;
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input int addr, input logic [31:0] e);
    pushExp(K_READ, nm, e);
    applyStimulus(1'b0, 1'b1, addr, 32'd0);
  endtask

  task automatic checkStatus(input string nm, input logic r, input logic d);
    pushExp(K_STATUS, nm, {30'b0, r, d});
    @(negedge clk);
    stat_req = 1'b1;
    @(negedge clk);
    stat_req = 1'b0;
  endtask

  task automatic checkValue(input string nm, input logic [31:0] v, input logic [31:0] e);
    chk_val = v;
    pushExp(K_VALUE, nm, e);
    @(negedge clk);
    val_req = 1'b1;
    @(negedge clk);
    val_req = 1'b0;
  endtask

  task automatic fillWeights(input logic [31:0] w1, input logic [31:0] w2);
    for (int n = 0; n < 32; n++) applyStimulus(1'b1, 1'b0, n, w1);
    for (int n = 32; n < 40; n++) applyStimulus(1'b1, 1'b0, n, w2);
  endtask

  task automatic fillInputs(input logic [31:0] v);
    for (int n = 0; n < 8; n++) applyStimulus(1'b1, 1'b0, 40 + n, v);
  endtask

  task automatic startRun(output int st);
    applyStimulus(1'b1, 1'b0, 48, 32'd1);
    st = cyc;
  endtask

  task automatic waitDone(input string nm, input int st);
    int guard = 0;
    while (!ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkValue(nm, ready ? 32'(cyc - st) : 32'hFFFF_FFFF, 32'(LAT));
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    checkStatus("reset_status", 1'b1, 1'b0);
    checkOutput("reset_w0", 0, 32'd0);
    checkOutput("reset_in0", 40, 32'd0);
    checkOutput("reset_ctrl", 48, 32'd0);
    checkOutput("reset_out0", 49, 32'd0);

    // Zero weights, arbitrary (partly negative) inputs
    for (int n = 0; n < 8; n++) applyStimulus(1'b1, 1'b0, 40 + n, 32'(n * 3 - 5));
    checkOutput("input_sign_ext", 40, 32'hFFFF_FFFB);
    applyStimulus(1'b1, 1'b0, 1, 32'hFFFF_FFFD);
    checkOutput("weight_sign_ext", 1, 32'hFFFF_FFFD);
    applyStimulus(1'b1, 1'b0, 1, 32'd0);
    pushExp(K_READ, "rw_same_cycle_old", 32'd0);
    applyStimulus(1'b1, 1'b1, 2, 32'd7);
    checkOutput("rw_same_cycle_new", 2, 32'd7);
    applyStimulus(1'b1, 1'b0, 2, 32'd0);
    applyStimulus(1'b1, 1'b0, 60, 32'd123);
    checkOutput("unmapped_read", 60, 32'd0);

    startRun(s);
    checkStatus("busy_status", 1'b0, 1'b0);
    waitDone("latency_zero_w", s);
    checkStatus("done_status", 1'b1, 1'b1);
    checkOutput("done_ctrl", 48, 32'd2);
    checkOutput("zero_w_out0", 49, 32'd500);
    checkOutput("zero_w_out1", 50, 32'd500);

    // All +1 weights, inputs 10: layer 2 saturates high
    fillWeights(32'd1, 32'd1);
    fillInputs(32'd10);
    startRun(s);
    checkStatus("start_clears_down", 1'b0, 1'b0);
    waitDone("latency_ones", s);
    checkOutput("clamp_hi_out0", 49, 32'd999);
    checkOutput("clamp_hi_out1", 50, 32'd999);

    // W1 -256, inputs 127: hidden saturates low
    fillWeights(32'hFFFF_FF00, 32'd1);
    fillInputs(32'd127);
    checkOutput("weight_min_read", 0, 32'hFFFF_FF00);
    startRun(s);
    waitDone("latency_neg", s);
    checkOutput("clamp_lo_out0", 49, 32'd500);
    checkOutput("clamp_lo_out1", 50, 32'd500);

    // Writes and restart while busy are ignored
    startRun(s);
    applyStimulus(1'b1, 1'b0, 0, 32'd5);
    applyStimulus(1'b1, 1'b0, 48, 32'd1);
    checkOutput("busy_write_ignored", 0, 32'hFFFF_FF00);
    checkOutput("busy_ctrl", 48, 32'd1);
    waitDone("latency_busy_writes", s);
    checkOutput("busy_run_out0", 49, 32'd500);

    // Reset asserted mid-run
    startRun(s);
    while (cyc - s < 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkStatus("midrun_reset_status", 1'b1, 1'b0);
    checkOutput("midrun_reset_out0", 49, 32'd0);
    checkOutput("midrun_reset_out1", 50, 32'd0);
    checkOutput("midrun_reset_w0", 0, 32'd0);

    // Output bias k=0 with zero weights
    applyStimulus(1'b1, 1'b0, 55, 32'd40);
`ifdef FF_NETWORK_BIAS_EN
    checkOutput("bias_read", 55, 32'd40);
`else
    checkOutput("bias_read", 55, 32'd0);
`endif
    startRun(s);
    waitDone("latency_bias", s);
`ifdef FF_NETWORK_BIAS_EN
    checkOutput("bias_out0", 49, 32'd510);
`else
    checkOutput("bias_out0", 49, 32'd500);
`endif
    checkOutput("bias_out1", 50, 32'd500);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
